// File: rtl/uart_nonce_tx.sv
// uart_nonce_tx: buffers golden nonces in a small FIFO and sends each one
// to the UART byte transmitter as a framed byte sequence
// (HEADER_BYTE, nonce LSB byte first, optional checksum).
// Define NONCE_TX_CHECKSUM_EN to append the checksum byte (6-byte frames);
// without it frames are 5 bytes and no checksum logic is built.
module uart_nonce_tx #(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] HEADER_BYTE = 8'h4E
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nonce_valid,
  input  logic [31:0] nonce,
  input  logic        tx_busy,
  output logic        tx_we,
  output logic [7:0]  tx_data,
  output logic        dropped,
  output logic        idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
`ifdef NONCE_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t      state, state_next;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [31:0] frame_q;
  logic [2:0]  byte_idx;
  logic [7:0]  cur_byte;
  logic [31:0] head;
  logic        full, push, pop, send_byte, advance;
`ifdef NONCE_TX_CHECKSUM_EN
  logic [7:0]  chk_q;
`endif

  // Fullness uses pre-edge occupancy, so a pop on the same edge never rescues a push.
  assign full = (count == DEPTH_CNT);
  assign push = nonce_valid && !full;
  assign head = fifo_mem[rd_ptr];
  assign idle = (state == ST_IDLE) && (count == '0);

  // FIFO storage: no reset needed, occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= nonce;
  end

  // FIFO pointers, occupancy and the registered overflow pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      dropped <= nonce_valid && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register; a reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic: IDLE pops, SEND waits for the transmitter, GAP covers busy latency.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    send_byte  = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((count != '0) && !tx_busy) begin
          pop        = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          send_byte  = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (byte_idx == LAST_IDX) begin
          state_next = ST_IDLE;
        end else begin
          advance    = 1'b1;
          state_next = ST_SEND;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Select the frame byte for the current index.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx)
      3'd0: cur_byte = HEADER_BYTE;
      3'd1: cur_byte = frame_q[7:0];
      3'd2: cur_byte = frame_q[15:8];
      3'd3: cur_byte = frame_q[23:16];
      3'd4: cur_byte = frame_q[31:24];
`ifdef NONCE_TX_CHECKSUM_EN
      3'd5: cur_byte = chk_q;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  // Frame register, byte index and registered transmitter strobe/data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q  <= '0;
      byte_idx <= '0;
      tx_we    <= 1'b0;
      tx_data  <= 8'h00;
`ifdef NONCE_TX_CHECKSUM_EN
      chk_q    <= 8'h00;
`endif
    end else begin
      tx_we <= send_byte;
      if (send_byte) tx_data <= cur_byte;
      if (pop) begin
        frame_q  <= head;
        byte_idx <= '0;
`ifdef NONCE_TX_CHECKSUM_EN
        chk_q    <= 8'h00 - (HEADER_BYTE + head[7:0] + head[15:8]
                             + head[23:16] + head[31:24]);
`endif
      end else if (advance) begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_nonce_tx.sv
// tb_uart_nonce_tx: self-checking bench for uart_nonce_tx.
// Frame length follows NONCE_TX_CHECKSUM_EN the same way the design does.
module tb_uart_nonce_tx;

  localparam int FIFO_DEPTH = 4;
`ifdef NONCE_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  typedef struct {
    logic [31:0] nonce;
    logic [7:0]  bytes [6];
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        nonce_valid;
  logic [31:0] nonce;
  logic        tx_busy;
  logic        tx_we;
  logic [7:0]  tx_data;
  logic        dropped;
  logic        idle;

  logic        busy_force = 1'b0;
  logic        busy_en = 1'b0;
  int          busy_len = 0;
  int          busy_cnt = 0;
  int          cyc = 0;

  logic [7:0]  cap_q [$];
  int          cap_cyc_q [$];
  logic [7:0]  exp_q [$];
  int          drop_cyc_q [$];
  int          proto_err = 0;
  logic        prev_we = 1'b0;

  int          checks = 0;
  int          failures = 0;

  vec_t        vecs [5];
  int          strobe_cyc, idle_cyc, gap, min_gap, burst;
  int          s_cyc [6];
  logic [31:0] rnd;

  uart_nonce_tx #(.FIFO_DEPTH(FIFO_DEPTH), .HEADER_BYTE(8'h4E)) dut (
    .clk(clk), .reset_n(reset_n), .nonce_valid(nonce_valid), .nonce(nonce),
    .tx_busy(tx_busy), .tx_we(tx_we), .tx_data(tx_data),
    .dropped(dropped), .idle(idle)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Behavioural byte transmitter: busy for busy_len cycles after each write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_we) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = busy_force | (busy_en & (busy_cnt != 0));

  // Monitor on the falling edge: capture bytes, drop pulses, protocol errors.
  always @(negedge clk) begin
    if (tx_we) begin
      cap_q.push_back(tx_data);
      cap_cyc_q.push_back(cyc);
      if (tx_busy) proto_err++;
      if (prev_we) proto_err++;
    end
    prev_we = tx_we;
    if (dropped) drop_cyc_q.push_back(cyc);
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] n);
    @(posedge clk); #1;
    nonce_valid = 1'b1;
    nonce = n;
  endtask

  task automatic releaseStimulus();
    @(posedge clk); #1;
    nonce_valid = 1'b0;
  endtask

  task automatic waitIdle(input int limit, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (idle) begin
        at_cyc = cyc;
        break;
      end
    end
    checkOutput("idle_reached", idle, 1'b1);
  endtask

  // Reference frame built from the framing rules with plain arithmetic.
  task automatic pushFrame(input logic [31:0] n);
    int b [6];
    int sum;
    b[0] = 'h4E;
    for (int i = 0; i < 4; i++) b[i+1] = int'(n[8*i +: 8]);
    sum = 0;
    for (int i = 0; i < 5; i++) sum += b[i];
    b[5] = (256 - (sum % 256)) % 256;
    for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(8'(b[i]));
  endtask

  task automatic compareStream(input string tag);
    int n;
    checkOutput({tag, "_len"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), {24'h0, cap_q[i]}, {24'h0, exp_q[i]});
    cap_q.delete();
    cap_cyc_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vecs[0].nonce = 32'h12345678; vecs[0].bytes = '{8'h4E, 8'h78, 8'h56, 8'h34, 8'h12, 8'h9E};
    vecs[1].nonce = 32'h00000000; vecs[1].bytes = '{8'h4E, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB2};
    vecs[2].nonce = 32'hFFFFFFFF; vecs[2].bytes = '{8'h4E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB6};
    vecs[3].nonce = 32'hDEADBEEF; vecs[3].bytes = '{8'h4E, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h7A};
    vecs[4].nonce = 32'h000000B2; vecs[4].bytes = '{8'h4E, 8'hB2, 8'h00, 8'h00, 8'h00, 8'h00};

    reset_n = 1'b1;
    nonce_valid = 1'b0;
    nonce = '0;
    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset_tx_we", tx_we, 1'b0);
    checkOutput("reset_tx_data", tx_data, 8'h00);
    checkOutput("reset_dropped", dropped, 1'b0);
    checkOutput("reset_idle", idle, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table vectors, transmitter always ready.
    for (int v = 0; v < 5; v++) begin
      cap_q.delete(); cap_cyc_q.delete();
      applyStimulus(vecs[v].nonce);
      strobe_cyc = cyc;
      releaseStimulus();
      waitIdle(200, idle_cyc);
      checkOutput($sformatf("vec%0d_len", v), cap_q.size(), FRAME_LEN);
      for (int i = 0; i < FRAME_LEN && i < cap_q.size(); i++)
        checkOutput($sformatf("vec%0d_byte%0d", v, i), {24'h0, cap_q[i]}, {24'h0, vecs[v].bytes[i]});
      if (cap_q.size() > 0) begin
        checkOutput($sformatf("vec%0d_latency", v), cap_cyc_q[0] - strobe_cyc, 3);
        for (int i = 1; i < cap_cyc_q.size(); i++)
          checkOutput($sformatf("vec%0d_spacing%0d", v, i), cap_cyc_q[i] - cap_cyc_q[i-1], 2);
        checkOutput($sformatf("vec%0d_idle_after_gap", v), idle_cyc - cap_cyc_q[cap_cyc_q.size()-1], 1);
      end
    end
    checkOutput("table_no_drops", drop_cyc_q.size(), 0);
    cap_q.delete(); cap_cyc_q.delete();

    // Slow transmitter: two nonces strobed on consecutive cycles.
    busy_len = 160;
    busy_en = 1'b1;
    applyStimulus(32'h00000000);
    applyStimulus(32'hFFFFFFFF);
    releaseStimulus();
    pushFrame(32'h00000000);
    pushFrame(32'hFFFFFFFF);
    waitIdle(5000, idle_cyc);
    min_gap = 1000000;
    for (int i = 1; i < cap_cyc_q.size(); i++) begin
      gap = cap_cyc_q[i] - cap_cyc_q[i-1];
      if (gap < min_gap) min_gap = gap;
    end
    checkOutput("busy_min_gap_ok", (min_gap > busy_len), 1'b1);
    compareStream("busy");
    checkOutput("busy_protocol", proto_err, 0);
    busy_en = 1'b0;
    busy_len = 0;

    // Overflow: transmitter held busy, six strobes into a 4-deep FIFO.
    drop_cyc_q.delete();
    busy_force = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(32'hA0000000 + k);
      s_cyc[k] = cyc;
    end
    releaseStimulus();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ovf_drop_count", drop_cyc_q.size(), 2);
    if (drop_cyc_q.size() == 2) begin
      checkOutput("ovf_drop5_cycle", drop_cyc_q[0], s_cyc[4] + 1);
      checkOutput("ovf_drop6_cycle", drop_cyc_q[1], s_cyc[5] + 1);
    end
    checkOutput("ovf_nothing_sent_while_busy", cap_q.size(), 0);
    checkOutput("ovf_not_idle", idle, 1'b0);
    busy_force = 1'b0;
    for (int k = 0; k < 4; k++) pushFrame(32'hA0000000 + k);
    waitIdle(500, idle_cyc);
    compareStream("ovf");

    // Reset during byte 3 of a frame with two more nonces queued.
    drop_cyc_q.delete();
    applyStimulus(32'h11111111);
    applyStimulus(32'h22222222);
    applyStimulus(32'h33333333);
    releaseStimulus();
    for (int i = 0; i < 100 && cap_q.size() < 3; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("rst_reached_byte3", (cap_q.size() == 3), 1'b1);
    checkOutput("rst_byte3_we_high", tx_we, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_tx_we", tx_we, 1'b0);
    checkOutput("rst_async_tx_data", tx_data, 8'h00);
    checkOutput("rst_async_idle", idle, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cap_q.delete(); cap_cyc_q.delete();
    repeat (40) @(posedge clk);
    #1;
    checkOutput("rst_no_resume", cap_q.size(), 0);
    checkOutput("rst_idle_after", idle, 1'b1);
    applyStimulus(32'hCAFEF00D);
    releaseStimulus();
    pushFrame(32'hCAFEF00D);
    waitIdle(200, idle_cyc);
    compareStream("fresh");

    // Random bursts (never more than the FIFO holds) against the reference model.
    busy_en = 1'b1;
    drop_cyc_q.delete();
    for (int r = 0; r < 25; r++) begin
      busy_len = $urandom_range(0, 6);
      burst = $urandom_range(1, FIFO_DEPTH);
      for (int b = 0; b < burst; b++) begin
        rnd = $urandom;
        pushFrame(rnd);
        applyStimulus(rnd);
        releaseStimulus();
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      waitIdle(2000, idle_cyc);
      compareStream($sformatf("rnd%0d", r));
    end
    checkOutput("rnd_no_drops", drop_cyc_q.size(), 0);
    checkOutput("final_protocol", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
